// File: rtl/mul16_seq.sv
// mul16_seq: multi-cycle radix-2 shift-add multiplier with start/busy/done handshake.
// Signed operands are multiplied as magnitudes and the sign is applied to the final product.
module mul16_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product_hi,
    output logic [WIDTH-1:0] product_lo
);
    localparam int CW = $clog2(WIDTH) + 1;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t             state;
    logic [2*WIDTH-1:0] acc, mcand, acc_nxt, res;
    logic [WIDTH-1:0]   mplr, a_abs, b_abs;
    logic [CW-1:0]      count;
    logic               neg;
    // Two's-complement negation of the most negative value wraps to itself, which is its correct magnitude.
    assign a_abs   = (signed_mode && multiplicand[WIDTH-1]) ? -multiplicand : multiplicand;
    assign b_abs   = (signed_mode && multiplier[WIDTH-1]) ? -multiplier : multiplier;
    assign acc_nxt = mplr[0] ? acc + mcand : acc;
    assign res     = neg ? -acc_nxt : acc_nxt;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            product_hi <= '0;
            product_lo <= '0;
            acc        <= '0;
            mcand      <= '0;
            mplr       <= '0;
            count      <= '0;
            neg        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        mcand <= {{WIDTH{1'b0}}, a_abs};
                        mplr  <= b_abs;
                        neg   <= signed_mode & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
                        acc   <= '0;
                        count <= '0;
                        busy  <= 1'b1;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    acc   <= acc_nxt;
                    mcand <= mcand << 1;
                    mplr  <= mplr >> 1;
                    count <= count + 1'b1;
                    // The last step folds straight into the registered product so done carries a valid result.
                    if (count == CW'(WIDTH - 1)) begin
                        {product_hi, product_lo} <= res;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mul16_seq.sv
// tb_mul16_seq: directed checks of latency, arithmetic corners, start filtering and mid-operation reset.
module tb_mul16_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        signed_mode = 1'b0;
    logic [15:0] multiplicand = '0;
    logic [15:0] multiplier = '0;
    logic        busy, done;
    logic [15:0] product_hi, product_lo;
    int          checks = 0;
    int          failures = 0;
    logic [31:0] last = '0;

    mul16_seq #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
        .multiplicand(multiplicand), .multiplier(multiplier),
        .busy(busy), .done(done), .product_hi(product_hi), .product_lo(product_lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One operation from the accepting edge through the done pulse; junk keeps start high with other operands.
    task automatic run(input string tag, input logic [15:0] a, input logic [15:0] b, input logic s,
                       input logic [31:0] exp, input bit junk);
        int lat = 1;
        int bcnt = 0;
        @(negedge clk);
        start = 1'b1; multiplicand = a; multiplier = b; signed_mode = s;
        @(negedge clk);
        start = junk; multiplicand = ~a; multiplier = a ^ b ^ 16'h5a5a; signed_mode = ~s;
        chk({tag, "_hold"}, {product_hi, product_lo}, last);
        while (!done && lat < 40) begin
            bcnt += int'(busy);
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'd17);
        chk({tag, "_busy_cycles"}, 32'(bcnt), 32'd16);
        chk({tag, "_product"}, {product_hi, product_lo}, exp);
        start = 1'b0;
        @(negedge clk);
        chk({tag, "_done_width"}, {31'b0, done}, 32'd0);
        chk({tag, "_idle_busy"}, {31'b0, busy}, 32'd0);
        last = exp;
    endtask

    initial begin
        int d1, d2, n;
        logic [15:0] ra, rb;
        logic rs;
        longint pa, pb;
        repeat (2) @(negedge clk);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_done", {31'b0, done}, 32'd0);
        chk("reset_product", {product_hi, product_lo}, 32'd0);
        rst_n = 1'b1;

        run("u3x5", 16'd3, 16'd5, 1'b0, 32'h0000_000F, 1'b0);
        run("u_max", 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001, 1'b0);
        run("s_m1xm1", 16'hFFFF, 16'hFFFF, 1'b1, 32'h0000_0001, 1'b0);
        run("s_minxmin", 16'h8000, 16'h8000, 1'b1, 32'h4000_0000, 1'b0);
        run("s_m3x7", 16'hFFFD, 16'h0007, 1'b1, 32'hFFFF_FFEB, 1'b0);
        run("s_minx0", 16'h8000, 16'h0000, 1'b1, 32'h0000_0000, 1'b0);
        run("s_minxm1", 16'h8000, 16'hFFFF, 1'b1, 32'h0000_8000, 1'b0);
        run("u_minxmin", 16'h8000, 16'h8000, 1'b0, 32'h4000_0000, 1'b0);
        run("junk_start", 16'h1234, 16'h0010, 1'b0, 32'h0001_2340, 1'b1);

        // Start held high: done pulses 18 cycles apart (one IDLE accept cycle between them).
        @(negedge clk);
        start = 1'b1; multiplicand = 16'd7; multiplier = 16'd9; signed_mode = 1'b0;
        d1 = 0; d2 = 0;
        for (int i = 1; i <= 45; i++) begin
            @(negedge clk);
            if (done && d1 == 0) d1 = i;
            else if (done && d2 == 0) d2 = i;
        end
        start = 1'b0;
        chk("b2b_first_done", 32'(d1), 32'd17);
        chk("b2b_second_done", 32'(d2), 32'd35);
        chk("b2b_product", {product_hi, product_lo}, 32'd63);
        n = 0;
        while (!done && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_third_done", {31'b0, done}, 32'd1);
        @(negedge clk);
        last = 32'd63;

        // Reset asserted at cycle T8 of an operation.
        start = 1'b1; multiplicand = 16'd1000; multiplier = 16'd1000; signed_mode = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        chk("rst_mid_busy_before", {31'b0, busy}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_busy", {31'b0, busy}, 32'd0);
        chk("rst_mid_done", {31'b0, done}, 32'd0);
        chk("rst_mid_product", {product_hi, product_lo}, 32'd0);
        rst_n = 1'b1;
        last = '0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n += int'(done);
        end
        chk("rst_mid_no_done", 32'(n), 32'd0);
        run("u100x200", 16'd100, 16'd200, 1'b0, 32'h0000_4E20, 1'b0);

        for (int i = 0; i < 200; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rs = 1'($urandom);
            if (i < 8) ra = (i % 2 == 0) ? 16'h8000 : 16'hFFFF;
            pa = rs ? longint'($signed(ra)) : longint'({16'b0, ra});
            pb = rs ? longint'($signed(rb)) : longint'({16'b0, rb});
            run("rand", ra, rb, rs, 32'(pa * pb), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
